// File: rtl/sr_pq_pkg.sv
// Shared types for the priority-queue storage: key/value payload, cell and op encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;

  // Key sits in the MSBs so a whole kv_t compares like {key,val}.
  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  typedef struct packed {
    kv_t  kv;
    logic valid;
  } cell_t;

  // Per-cycle operation, already gated against full/empty by the top level.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_BOTH = 2'd3
  } op_e;

endpackage

// File: rtl/sr_pq_if.sv
// Enq/deq handshake bundle between a PQ client (master) and the queue storage (slave).
// Latency: n/a (wires only).
// Backpressure: client must consult full/empty before issuing; the queue drops illegal requests.
interface sr_pq_if;
  import pq_pkg::*;

  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic empty;
  logic full;

  modport master (output enq, output deq, output kvi, input kvo, input empty, input full);
  modport slave  (input enq, input deq, input kvi, output kvo, output empty, output full);

endinterface

// File: rtl/sr_pq_cell.sv
// One systolic storage slot: picks its next contents from kvi, itself or a neighbour.
// Latency: 1 cycle, contents registered.
// Backpressure: none; op is pre-gated by the top level.
module sr_pq_cell
  import pq_pkg::*;
#(
  parameter bit IS_HEAD = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  cell_t prev_cell,
  input  cell_t next_cell,
  input  kv_t   kvi,
  input  logic  gt_prev,
  input  logic  gt_next,
  input  op_e   op,
  output cell_t cell_q,
  output logic  gt
);

  cell_t cell_d;
  cell_t kvi_cell;

  // Incoming key belongs at or before this slot; strict compare keeps equal keys FIFO.
  always_comb begin
    gt = !cell_q.valid || (kvi.key < cell_q.kv.key);
  end

  // Choose next contents: shift right on insert, shift left on remove, both for replace.
  always_comb begin
    kvi_cell       = '0;
    kvi_cell.kv    = kvi;
    kvi_cell.valid = 1'b1;
    cell_d         = cell_q;
    case (op)
      OP_ENQ: begin
        if (gt) cell_d = gt_prev ? prev_cell : kvi_cell;
      end
      OP_DEQ: begin
        cell_d = next_cell;
      end
      OP_BOTH: begin
        if (!gt_next)              cell_d = next_cell;
        else if (IS_HEAD || !gt)   cell_d = kvi_cell;
        else                       cell_d = cell_q;
      end
      default: cell_d = cell_q;
    endcase
  end

  // Slot register, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) cell_q <= '0;
    else     cell_q <= cell_d;
  end

endmodule

// File: rtl/sr_pq.sv
// Shift-register priority queue: smallest key at head, FIFO among equal keys.
// Latency: 1 cycle from enq/deq to updated kvo/empty/full; one op (or enq+deq) per cycle.
// Backpressure: enq on full (without deq) and deq on empty are silently dropped.
module sr_pq
  import pq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic    clk,
  input logic    rst,
  sr_pq_if.slave pq
);

  localparam int CW = $clog2(DEPTH + 1);

  // c[DEPTH] and gt[DEPTH] are the tail tie-offs: an empty slot past the end.
  cell_t [DEPTH:0] c;
  logic  [DEPTH:0] gt;
  op_e             op;

  logic [CW-1:0] count_d, count_q;
  logic          empty_d, empty_q;
  logic          full_d, full_q;

  assign c[DEPTH]  = '0;
  assign gt[DEPTH] = 1'b1;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    cell_t prev_c;
    logic  gt_p;
    if (i == 0) begin : g_head
      assign prev_c = '0;
      assign gt_p   = 1'b0;
    end else begin : g_body
      assign prev_c = c[i-1];
      assign gt_p   = gt[i-1];
    end
    sr_pq_cell #(.IS_HEAD(i == 0)) u_cell (
      .clk       (clk),
      .rst       (rst),
      .prev_cell (prev_c),
      .next_cell (c[i+1]),
      .kvi       (pq.kvi),
      .gt_prev   (gt_p),
      .gt_next   (gt[i+1]),
      .op        (op),
      .cell_q    (c[i]),
      .gt        (gt[i])
    );
  end

  // Decode request into an accepted op; enq+deq on empty degrades to a plain enq.
  always_comb begin
    op = OP_HOLD;
    if (pq.enq && pq.deq && !empty_q) op = OP_BOTH;
    else if (pq.enq && !full_q)       op = OP_ENQ;
    else if (pq.deq && !empty_q)      op = OP_DEQ;
  end

  // Occupancy tracks only accepted ops; flags are precomputed so they leave a flop.
  always_comb begin
    count_d = count_q;
    case (op)
      OP_ENQ:  count_d = count_q + CW'(1);
      OP_DEQ:  count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  // Occupancy and status flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  assign pq.kvo   = c[0].kv;
  assign pq.empty = empty_q;
  assign pq.full  = full_q;

endmodule

// File: tb/tb_sr_pq.sv
// Bench for sr_pq: directed scenarios plus random traffic against a sorted-queue model.
module tb_sr_pq;
  import pq_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  sr_pq_if pq ();

  sr_pq #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .pq  (pq)
  );

  int  tests  = 0;
  int  fails  = 0;
  bit  chk_en = 1'b0;
  kv_t mdl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic kv_t mk(int k, int v);
    kv_t r;
    r.key = KEY_WIDTH'(k);
    r.val = VAL_WIDTH'(v);
    return r;
  endfunction

  // Reference: ordered list; insert after every entry whose key is <= the new key.
  task automatic mdl_apply(bit e, bit d, bit r, kv_t k);
    int pos;
    bit found;
    bit dd;
    bit de;
    if (r) begin
      mdl.delete();
      return;
    end
    dd = d && (mdl.size() > 0);
    de = e && ((mdl.size() < DEPTH) || dd);
    if (dd) void'(mdl.pop_front());
    if (de) begin
      pos   = mdl.size();
      found = 1'b0;
      for (int i = 0; i < mdl.size(); i++) begin
        if (!found && (mdl[i].key > k.key)) begin
          pos   = i;
          found = 1'b1;
        end
      end
      mdl.insert(pos, k);
    end
  endtask

  task automatic step(bit e, bit d, bit r, kv_t k);
    @(negedge clk);
    pq.enq = e;
    pq.deq = d;
    pq.kvi = k;
    rst    = r;
    @(posedge clk);
    mdl_apply(e, d, r, k);
    #1;
    pq.enq = 1'b0;
    pq.deq = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic chk_kv(string nm, kv_t exp);
    tests++;
    if (pq.kvo !== exp) begin
      fails++;
      $display("FAIL %s: kvo got %h want %h", nm, pq.kvo, exp);
    end
  endtask

  task automatic chk_bit(string nm, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Every cycle: outputs must match the model's occupancy and head.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (pq.empty !== (mdl.size() == 0) || pq.full !== (mdl.size() == DEPTH)) begin
        fails++;
        $display("FAIL cyc_flags: empty/full got %b/%b want %b/%b", pq.empty, pq.full,
                 (mdl.size() == 0), (mdl.size() == DEPTH));
      end else if (mdl.size() > 0) begin
        if (pq.kvo !== mdl[0]) begin
          fails++;
          $display("FAIL cyc_head: kvo got %h want %h", pq.kvo, mdl[0]);
        end
      end
    end
  end

  initial begin
    bit  e, d, r;
    int  enq_pct;
    pq.enq = 1'b0;
    pq.deq = 1'b0;
    pq.kvi = '0;
    rst    = 1'b1;

    // Reset state
    step(0, 0, 1, mk(0, 0));
    chk_en = 1'b1;
    chk_bit("rst_empty", pq.empty, 1'b1);
    chk_bit("rst_full", pq.full, 1'b0);
    chk_kv("rst_kvo", mk(0, 0));

    // Basic ordering
    step(1, 0, 0, mk(8, 14));
    step(1, 0, 0, mk(11, 11));
    step(1, 0, 0, mk(9, 9));
    step(1, 0, 0, mk(10, 10));
    chk_kv("ord_h0", mk(8, 14));
    step(0, 1, 0, mk(0, 0));
    chk_kv("ord_h1", mk(9, 9));
    step(0, 1, 0, mk(0, 0));
    chk_kv("ord_h2", mk(10, 10));
    step(0, 1, 0, mk(0, 0));
    chk_kv("ord_h3", mk(11, 11));
    step(0, 1, 0, mk(0, 0));
    chk_bit("ord_empty", pq.empty, 1'b1);

    // Ties leave in arrival order
    step(1, 0, 0, mk(9, 10));
    step(1, 0, 0, mk(9, 11));
    step(1, 0, 0, mk(9, 12));
    chk_kv("tie_h0", mk(9, 10));
    step(0, 1, 0, mk(0, 0));
    chk_kv("tie_h1", mk(9, 11));
    step(0, 1, 0, mk(0, 0));
    chk_kv("tie_h2", mk(9, 12));
    step(0, 1, 0, mk(0, 0));

    // Full: drop plain enq, accept replace
    for (int k = 1; k <= 8; k++) step(1, 0, 0, mk(k, 20 + k));
    chk_bit("full_set", pq.full, 1'b1);
    step(1, 0, 0, mk(0, 5));
    chk_bit("full_drop_full", pq.full, 1'b1);
    chk_kv("full_drop_head", mk(1, 21));
    step(1, 1, 0, mk(3, 13));
    chk_bit("full_both_full", pq.full, 1'b1);
    chk_kv("full_both_head", mk(2, 22));
    step(0, 1, 0, mk(0, 0));
    chk_kv("full_tie_a", mk(3, 23));
    step(0, 1, 0, mk(0, 0));
    chk_kv("full_tie_b", mk(3, 13));
    for (int k = 0; k < 6; k++) step(0, 1, 0, mk(0, 0));
    chk_bit("full_drained", pq.empty, 1'b1);

    // Empty corner cases
    step(1, 1, 0, mk(12, 12));
    chk_bit("emp_both_empty", pq.empty, 1'b0);
    chk_kv("emp_both_head", mk(12, 12));
    step(0, 1, 0, mk(0, 0));
    step(0, 1, 0, mk(0, 0));
    chk_bit("emp_deq_empty", pq.empty, 1'b1);

    // Mixed replace removes the small head
    step(1, 0, 0, mk(10, 10));
    step(1, 0, 0, mk(15, 15));
    step(1, 0, 0, mk(1, 11));
    step(1, 1, 0, mk(12, 12));
    chk_kv("mix_h0", mk(10, 10));
    step(0, 1, 0, mk(0, 0));
    chk_kv("mix_h1", mk(12, 12));
    step(0, 1, 0, mk(0, 0));
    chk_kv("mix_h2", mk(15, 15));
    step(0, 1, 0, mk(0, 0));

    // Reset wins over a same-cycle enq
    step(1, 0, 0, mk(5, 5));
    step(1, 0, 0, mk(6, 6));
    step(1, 0, 0, mk(7, 7));
    step(1, 0, 1, mk(2, 2));
    chk_bit("mrst_empty", pq.empty, 1'b1);
    chk_bit("mrst_full", pq.full, 1'b0);
    chk_kv("mrst_kvo", mk(0, 0));
    step(0, 0, 0, mk(0, 0));
    chk_bit("mrst_stay_empty", pq.empty, 1'b1);

    // Random traffic, alternating fill-heavy and drain-heavy phases
    for (int n = 0; n < 3000; n++) begin
      enq_pct = ((n / 200) % 2 == 0) ? 75 : 30;
      e = ($urandom_range(0, 99) < enq_pct);
      d = ($urandom_range(0, 99) < (100 - enq_pct));
      r = ($urandom_range(0, 299) == 0);
      step(e, d, r, mk($urandom_range(0, 15), $urandom_range(0, 255)));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
